// File: rtl/rotation_reg_pkg.sv
// Shared definitions for the rotation SIPO/PISO pair: FSM encodings,
// bit-counter sizing and word rotate helpers.
package rotation_reg_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam int ROT_MAX_W = 64;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Rotate the low 'width' bits of x; bits above 'width' come back zero.
    function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] x,
                                                  input int width, input int rot);
        logic [ROT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROT_MAX_W; i++) begin
            if (i < width) r[6'((i + rot) % width)] = x[6'(i)];
        end
        return r;
    endfunction

    function automatic logic [ROT_MAX_W-1:0] rotr(input logic [ROT_MAX_W-1:0] x,
                                                  input int width, input int rot);
        logic [ROT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROT_MAX_W; i++) begin
            if (i < width) r[6'(i)] = x[6'((i + rot) % width)];
        end
        return r;
    endfunction

endpackage

// File: rtl/parameterized_rotation_piso_if.sv
// Parallel-word handshake plus serial output bundle of the rotation PISO.
interface parameterized_rotation_piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_done;
    logic             busy;

    modport master (
        output in_data, in_valid, shift_en,
        input  in_ready, serial_out, serial_valid, frame_done, busy
    );

    modport slave (
        input  in_data, in_valid, shift_en,
        output in_ready, serial_out, serial_valid, frame_done, busy
    );
endinterface

// File: rtl/parameterized_rotation_piso_hold_buf.sv
// One-entry valid/ready holding buffer in front of the PISO shifter.
module piso_hold_buf
    import rotation_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             push;

    assign in_ready_o = !full_q;
    assign push       = in_valid_i && !full_q;

    // A push on the same edge as a pop leaves the buffer full with the new word.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) full_d = 1'b0;
        if (push) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/parameterized_rotation_piso.sv
// Parallel-in serial-out transmitter: buffers one word, left-rotates it on
// load and shifts it out one bit per shift_en strobe with frame markers.
module parameterized_rotation_piso
    import rotation_reg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ROTATION  = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    parameterized_rotation_piso_if.slave bus_if
);

    localparam int CW = cnt_width(WIDTH);

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] hold_rot;
    logic             pop;
    logic             last;
    logic             out_bit;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_nx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             svld_q, svld_d;
    logic             fdone_q, fdone_d;

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  (bus_if.in_data),
        .in_valid_i (bus_if.in_valid),
        .in_ready_o (bus_if.in_ready),
        .pop_i      (pop),
        .data_o     (hold_data),
        .full_o     (hold_full)
    );

    generate
        if (ROTATION == 0) begin : g_norot
            assign hold_rot = hold_data;
        end else begin : g_rot
            assign hold_rot = {hold_data[WIDTH-1-ROTATION:0], hold_data[WIDTH-1:WIDTH-ROTATION]};
        end

        if (MSB_FIRST) begin : g_msb
            assign out_bit  = shift_q[WIDTH-1];
            assign shift_nx = {shift_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign out_bit  = shift_q[0];
            assign shift_nx = {1'b0, shift_q[WIDTH-1:1]};
        end
    endgenerate

    assign last = (state_q == SHIFT) && bus_if.shift_en && (cnt_q == CW'(WIDTH - 1));
    assign pop  = hold_full && ((state_q == IDLE) || last);

    // On the last bit a waiting word reloads directly, so frames stay contiguous.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        svld_d  = 1'b0;
        fdone_d = 1'b0;
        if (state_q == IDLE) begin
            if (hold_full) begin
                shift_d = hold_rot;
                cnt_d   = '0;
                state_d = SHIFT;
            end
        end else if (bus_if.shift_en) begin
            sout_d  = out_bit;
            svld_d  = 1'b1;
            shift_d = shift_nx;
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                fdone_d = 1'b1;
                cnt_d   = '0;
                if (hold_full) shift_d = hold_rot;
                else           state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            svld_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            svld_q  <= svld_d;
            fdone_q <= fdone_d;
        end
    end

    assign bus_if.serial_out   = sout_q;
    assign bus_if.serial_valid = svld_q;
    assign bus_if.frame_done   = fdone_q;
    assign bus_if.busy         = (state_q == SHIFT) || hold_full;

endmodule

// File: tb/tb_parameterized_rotation_piso.sv
// Directed bench for the rotation PISO: five parameter variants share one
// stimulus stream; received bit streams are compared with hand-computed words.
module tb_parameterized_rotation_piso;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       shift_en = 1'b0;
    int         se_mode = 0;   // 0 off, 1 always, 2 one-in-three

    always #5 clk = ~clk;

    parameterized_rotation_piso_if #(.WIDTH(8)) ia ();
    parameterized_rotation_piso_if #(.WIDTH(8)) ib ();
    parameterized_rotation_piso_if #(.WIDTH(8)) ic ();
    parameterized_rotation_piso_if #(.WIDTH(8)) id ();
    parameterized_rotation_piso_if #(.WIDTH(8)) ie ();

    assign ia.in_data = in_data;  assign ia.in_valid = in_valid;  assign ia.shift_en = shift_en;
    assign ib.in_data = in_data;  assign ib.in_valid = in_valid;  assign ib.shift_en = shift_en;
    assign ic.in_data = in_data;  assign ic.in_valid = in_valid;  assign ic.shift_en = shift_en;
    assign id.in_data = in_data;  assign id.in_valid = in_valid;  assign id.shift_en = shift_en;
    assign ie.in_data = in_data;  assign ie.in_valid = in_valid;  assign ie.shift_en = shift_en;

    parameterized_rotation_piso #(.WIDTH(8), .ROTATION(0), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus_if(ia));
    parameterized_rotation_piso #(.WIDTH(8), .ROTATION(3), .MSB_FIRST(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus_if(ib));
    parameterized_rotation_piso #(.WIDTH(8), .ROTATION(0), .MSB_FIRST(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .bus_if(ic));
    parameterized_rotation_piso #(.WIDTH(8), .ROTATION(5), .MSB_FIRST(1'b1)) u_d (.clk(clk), .rst_n(rst_n), .bus_if(id));
    parameterized_rotation_piso #(.WIDTH(8), .ROTATION(5), .MSB_FIRST(1'b0)) u_e (.clk(clk), .rst_n(rst_n), .bus_if(ie));

    logic [4:0] sv, so, fd;
    assign sv = {ie.serial_valid, id.serial_valid, ic.serial_valid, ib.serial_valid, ia.serial_valid};
    assign so = {ie.serial_out,   id.serial_out,   ic.serial_out,   ib.serial_out,   ia.serial_out};
    assign fd = {ie.frame_done,   id.frame_done,   ic.frame_done,   ib.frame_done,   ia.frame_done};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected serial word per variant, first bit received in bit 7:
    // exp[0] R0/MSB, exp[1] R3/MSB, exp[2] R0/LSB, exp[3] R5/MSB, exp[4] R5/LSB.
    typedef struct packed {
        logic [7:0]      din;
        logic [4:0][7:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] din, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.din = din;
        v.exp[0] = a; v.exp[1] = b; v.exp[2] = c; v.exp[3] = d; v.exp[4] = e;
        return v;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] w, input int r);
        return 8'((w >> r) | (w << (8 - r)));
    endfunction

    // Receive-side bookkeeping
    int         cyc = 0;
    logic       se_last = 1'b0;
    logic [7:0] acc [5];
    int         cur_n [5];
    logic [7:0] frm [5][512];
    int         nfr [5];
    int         fb_cyc [512];
    int         fd_cyc [512];
    int         fd_bad = 0, strobe_bad = 0, rdy_bad = 0;
    int         run = 0, maxrun = 0;
    logic       prev_sv = 1'b0;

    initial begin
        for (int d = 0; d < 5; d++) begin
            acc[d] = '0; cur_n[d] = 0; nfr[d] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            se_last = shift_en;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (se_mode)
                1:       shift_en = 1'b1;
                2:       shift_en = ((cyc % 3) == 0);
                default: shift_en = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int d = 0; d < 5; d++) begin
                    acc[d] = '0; cur_n[d] = 0;
                end
                prev_sv = 1'b0;
            end else begin
                for (int d = 0; d < 5; d++) begin
                    if (sv[d]) begin
                        acc[d] = {acc[d][6:0], so[d]};
                        cur_n[d]++;
                        if (d == 0 && cur_n[0] == 1) fb_cyc[nfr[0]] = cyc;
                        if (!se_last) strobe_bad++;
                    end
                    if (fd[d]) begin
                        if (!sv[d] || cur_n[d] != 8) fd_bad++;
                        if (d == 0) fd_cyc[nfr[0]] = cyc;
                        frm[d][nfr[d]] = acc[d];
                        nfr[d]++;
                        cur_n[d] = 0;
                    end
                end
                if (sv[0]) begin
                    run = prev_sv ? run + 1 : 1;
                    if (run > maxrun) maxrun = run;
                end
                prev_sv = sv[0];
                if (!ia.in_ready && !ia.busy) rdy_bad++;
            end
        end
    end

    task automatic send(input logic [7:0] w, input bit keep, output int ac);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        while (!ia.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        ac = cyc;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while ((nfr[0] < target || nfr[4] < target) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("frames_arrived", 32'(nfr[0] >= target && nfr[4] >= target), 32'd1);
    endtask

    task automatic chk_frame(input string name, input int k, input vec_t v);
        for (int d = 0; d < 5; d++)
            chk($sformatf("%s_dut%0d", name, d), 32'(frm[d][k]), 32'(v.exp[d]));
    endtask

    vec_t vecs [8];
    int   base = 0;
    int   ac = 0;
    int   n = 0;
    logic [7:0] rw [256];

    initial begin
        vecs[0] = mk(8'hA5, 8'hA5, 8'h2D, 8'hA5, 8'hB4, 8'h2D);
        vecs[1] = mk(8'h81, 8'h81, 8'h0C, 8'h81, 8'h30, 8'h0C);
        vecs[2] = mk(8'h01, 8'h01, 8'h08, 8'h80, 8'h20, 8'h04);
        vecs[3] = mk(8'h3C, 8'h3C, 8'hE1, 8'h3C, 8'h87, 8'hE1);
        vecs[4] = mk(8'h12, 8'h12, 8'h90, 8'h48, 8'h42, 8'h42);
        vecs[5] = mk(8'h34, 8'h34, 8'hA1, 8'h2C, 8'h86, 8'h61);
        vecs[6] = mk(8'h56, 8'h56, 8'hB2, 8'h6A, 8'hCA, 8'h53);
        vecs[7] = mk(8'hF0, 8'hF0, 8'h87, 8'h0F, 8'h1E, 8'h78);

        // Reset state, with shift_en already high
        se_mode = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_serial_out",   32'(ia.serial_out),   32'd0);
        chk("rst_serial_valid", 32'(ia.serial_valid), 32'd0);
        chk("rst_frame_done",   32'(ia.frame_done),   32'd0);
        chk("rst_busy",         32'(ia.busy),         32'd0);
        chk("rst_in_ready",     32'(ia.in_ready),     32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single words, continuous strobe
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].din, 1'b0, ac);
            wait_frames(base + 1);
            chk_frame($sformatf("single%0d", i), base, vecs[i]);
            if (i == 0) chk("first_bit_latency", 32'(fb_cyc[base] - ac), 32'd2);
            base++;
            repeat (2) @(negedge clk);
        end

        // Back-to-back words with in_valid held high
        maxrun = 0;
        send(vecs[4].din, 1'b1, ac);
        send(vecs[5].din, 1'b1, ac);
        send(vecs[6].din, 1'b0, ac);
        wait_frames(base + 3);
        for (int i = 0; i < 3; i++) chk_frame($sformatf("b2b%0d", i), base + i, vecs[4 + i]);
        chk("b2b_contiguous_bits", 32'(maxrun), 32'd24);
        chk("b2b_frame_gap1", 32'(fd_cyc[base + 1] - fd_cyc[base]), 32'd8);
        chk("b2b_frame_gap2", 32'(fd_cyc[base + 2] - fd_cyc[base + 1]), 32'd8);
        base += 3;
        repeat (2) @(negedge clk);

        // One-in-three strobe duty
        se_mode = 2;
        send(vecs[7].din, 1'b0, ac);
        wait_frames(base + 1);
        chk_frame("duty", base, vecs[7]);
        chk("duty_span", 32'(fd_cyc[base] - fb_cyc[base]), 32'd21);
        base++;
        se_mode = 1;
        repeat (3) @(negedge clk);

        // Reset mid-frame with the hold buffer occupied
        send(8'hFF, 1'b0, ac);
        send(8'h77, 1'b0, ac);
        n = 0;
        while (cur_n[0] != 4 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("midframe_reached_bit4", 32'(cur_n[0]), 32'd4);
        chk("midframe_hold_full", 32'(ia.in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_serial_out",   32'(ia.serial_out),   32'd0);
        chk("abort_serial_valid", 32'(ia.serial_valid), 32'd0);
        chk("abort_busy",         32'(ia.busy),         32'd0);
        chk("abort_in_ready",     32'(ia.in_ready),     32'd1);
        chk("abort_busy_r5",      32'(ie.busy),         32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(vecs[3].din, 1'b0, ac);
        wait_frames(base + 1);
        repeat (12) @(negedge clk);
        chk("after_abort_frame_count", 32'(nfr[0]), 32'(base + 1));
        chk_frame("after_abort", base, vecs[3]);
        base++;

        // Random words recovered through a receive-side rotate-back
        for (int k = 0; k < 256; k++) rw[k] = 8'($urandom);
        for (int k = 0; k < 256; k++) send(rw[k], 1'b1, ac);
        in_valid = 1'b0;
        wait_frames(base + 256);
        for (int k = 0; k < 256; k++) begin
            chk("loop_r0_msb", 32'(frm[0][base + k]), 32'(rw[k]));
            chk("loop_r5_msb", 32'(rotr8(frm[3][base + k], 5)), 32'(rw[k]));
            chk("loop_r5_lsb", 32'(rotr8(rev8(frm[4][base + k]), 5)), 32'(rw[k]));
        end
        base += 256;

        chk("frame_done_with_8th_bit", 32'(fd_bad), 32'd0);
        chk("valid_only_after_strobe", 32'(strobe_bad), 32'd0);
        chk("ready_low_implies_busy", 32'(rdy_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
